// File: rtl/qsys_led_master_pkg.sv
// Shared types and constants for the LED pattern Avalon-MM master.
package qsys_led_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StWrite,
    StRead,
    StCheck,
    StRotate
  } led_state_e;

  localparam int unsigned ErrCntW        = 16;
  localparam logic [31:0] DefInitPattern = 32'h5A5A5A5A;
  localparam logic [31:0] DefCmpMask     = 32'h00000FFF;

  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

endpackage

// File: rtl/qsys_tick_gen.sv
// Period down-counter: single-cycle tick every PERIOD enabled cycles, restartable via clear.
module qsys_tick_gen #(
  parameter int unsigned PERIOD = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned     CntW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(PERIOD - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= Reload;
    end else if (i_clr) begin
      r_cnt <= Reload;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? Reload : r_cnt - CntW'(1);
    end
  end

  assign o_tick = i_en && !i_clr && (r_cnt == '0);

endmodule

// File: rtl/qsys_led_pattern_master.sv
// Avalon-MM self-test master: periodically writes a rotating pattern to one slave word.
// Optional readback/compare is enabled with `define QSYS_LED_MASTER_READBACK_EN.
module qsys_led_pattern_master
  import qsys_led_master_pkg::*;
#(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned TARGET_ADDR  = 0,
  parameter int unsigned PERIOD       = 50_000_000,
  parameter logic [31:0] INIT_PATTERN = DefInitPattern,
  parameter logic [31:0] CMP_MASK     = DefCmpMask
) (
  input  logic               csi_MCLK_clk,
  input  logic               rsi_MRST_reset_n,
  output logic [ADDR_W-1:0]  avm_M_address,
  output logic               avm_M_read,
  output logic               avm_M_write,
  output logic [31:0]        avm_M_writedata,
  input  logic [31:0]        avm_M_readdata,
  input  logic               avm_M_waitrequest,
  input  logic               coe_ENABLE,
  output logic               coe_BUSY,
  output logic               coe_ERR,
  output logic [ErrCntW-1:0] coe_ERRCNT
);

  led_state_e  r_state;
  led_state_e  w_state_next;
  logic [31:0] r_pattern;
  logic        r_wait_entry;
  logic        w_tick;
  logic        w_tick_clr;
  logic        w_tick_en;

  // First WAIT cycle only restarts the counter, so WAIT lasts PERIOD + 1 cycles.
  assign w_tick_clr = (r_state == StWait) && r_wait_entry;
  assign w_tick_en  = (r_state == StWait) && !r_wait_entry;

  qsys_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick_gen (
    .i_clk   (csi_MCLK_clk),
    .i_rst_n (rsi_MRST_reset_n),
    .i_clr   (w_tick_clr),
    .i_en    (w_tick_en),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (coe_ENABLE) w_state_next = StWait;
      end
      StWait: begin
        if (!coe_ENABLE) w_state_next = StIdle;
        else if (w_tick) w_state_next = StWrite;
      end
      StWrite: begin
`ifdef QSYS_LED_MASTER_READBACK_EN
        if (!avm_M_waitrequest) w_state_next = StRead;
`else
        if (!avm_M_waitrequest) w_state_next = StRotate;
`endif
      end
`ifdef QSYS_LED_MASTER_READBACK_EN
      StRead: begin
        if (!avm_M_waitrequest) w_state_next = StCheck;
      end
      StCheck: begin
        w_state_next = StRotate;
      end
`endif
      StRotate: begin
        w_state_next = coe_ENABLE ? StWait : StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_state      <= StIdle;
      r_wait_entry <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wait_entry <= (w_state_next == StWait) && (r_state != StWait);
    end
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_pattern <= INIT_PATTERN;
    end else if (r_state == StRotate) begin
      r_pattern <= rotl1(r_pattern);
    end
  end

  assign avm_M_address   = ADDR_W'(TARGET_ADDR);
  assign avm_M_write     = (r_state == StWrite);
  assign avm_M_writedata = r_pattern;
  assign coe_BUSY        = r_state inside {StWrite, StRead, StCheck, StRotate};

`ifdef QSYS_LED_MASTER_READBACK_EN
  logic               r_err;
  logic [ErrCntW-1:0] r_errcnt;
  logic               w_rd_done;
  logic               w_mismatch;

  assign w_rd_done  = (r_state == StRead) && !avm_M_waitrequest;
  assign w_mismatch = |((avm_M_readdata ^ r_pattern) & CMP_MASK);

  // Compare against readdata at acceptance so ERR/ERRCNT are already valid in CHECK.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_err    <= 1'b0;
      r_errcnt <= '0;
    end else if (w_rd_done && w_mismatch) begin
      r_err <= 1'b1;
      if (r_errcnt != '1) r_errcnt <= r_errcnt + ErrCntW'(1);
    end
  end

  assign avm_M_read = (r_state == StRead);
  assign coe_ERR    = r_err;
  assign coe_ERRCNT = r_errcnt;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^{avm_M_readdata, CMP_MASK};

  assign avm_M_read = 1'b0;
  assign coe_ERR    = 1'b0;
  assign coe_ERRCNT = '0;
`endif

endmodule

// File: tb/tb_qsys_led_pattern_master.sv
// Self-checking bench for qsys_led_pattern_master; covers both QSYS_LED_MASTER_READBACK_EN builds.
module tb_qsys_led_pattern_master;

  localparam int unsigned Period  = 8;
  localparam int unsigned Target  = 5;
  localparam logic [31:0] InitPat = 32'h5A5A5A5A;
  localparam logic [31:0] CmpMask = 32'h00000FFF;

  logic        clk;
  logic        rst_n;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        waitreq;
  logic        en;
  logic        busy;
  logic        err;
  logic [15:0] errcnt;

  qsys_led_pattern_master #(
    .ADDR_W       (4),
    .TARGET_ADDR  (Target),
    .PERIOD       (Period),
    .INIT_PATTERN (InitPat),
    .CMP_MASK     (CmpMask)
  ) dut (
    .csi_MCLK_clk      (clk),
    .rsi_MRST_reset_n  (rst_n),
    .avm_M_address     (addr),
    .avm_M_read        (rd),
    .avm_M_write       (wr),
    .avm_M_writedata   (wdata),
    .avm_M_readdata    (rdata),
    .avm_M_waitrequest (waitreq),
    .coe_ENABLE        (en),
    .coe_BUSY          (busy),
    .coe_ERR           (err),
    .coe_ERRCNT        (errcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int cyc;
  int last_wr;
  int exp_gap;

  // Reference model state
  logic [31:0] m_pat;
  logic        m_err;
  logic [15:0] m_cnt;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_wr", 32'(wr), 32'd0);
      chk("idle_rd", 32'(rd), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic expect_write_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(Period) + 20; i++) begin
      if (wr === 1'b1) begin
        ok = 1'b1;
        break;
      end
      chk("wait_rd", 32'(rd), 32'd0);
      chk("wait_busy", 32'(busy), 32'd0);
      step();
    end
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL write_timeout observed=no_write expected=write_within_%0d", Period + 20);
    end
    if (ok) begin
      if (exp_gap >= 0) chk("write_gap", 32'(cyc - last_wr), 32'(exp_gap));
      last_wr = cyc;
      chk("wdata", wdata, m_pat);
      chk("addr", 32'(addr), 32'(Target));
      chk("busy_wr", 32'(busy), 32'd1);
      chk("rd_excl_wr", 32'(rd), 32'd0);
    end
  endtask

  task automatic run_xfer(input int wr_wait, input int rd_wait, input logic [31:0] rd_xor,
                          input bit drop_en);
    bit ok;
    int xfer;
    expect_write_start(ok);
    if (!ok) return;
    if (drop_en) en = 1'b0;
    rdata = $urandom;
    for (int i = 0; i < wr_wait; i++) begin
      waitreq = 1'b1;
      step();
      chk("wr_hold", 32'(wr), 32'd1);
      chk("wdata_stable", wdata, m_pat);
      chk("rd_excl_hold", 32'(rd), 32'd0);
    end
    waitreq = 1'b0;
    step();
    xfer = wr_wait + 1 + 1;
`ifdef QSYS_LED_MASTER_READBACK_EN
    chk("rd_strobe", 32'(rd), 32'd1);
    chk("wr_off_rd", 32'(wr), 32'd0);
    rdata = m_pat ^ rd_xor;
    for (int i = 0; i < rd_wait; i++) begin
      waitreq = 1'b1;
      step();
      chk("rd_hold", 32'(rd), 32'd1);
      chk("wr_off_hold", 32'(wr), 32'd0);
    end
    waitreq = 1'b0;
    step();
    if ((rd_xor & CmpMask) != 32'd0) begin
      m_err = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    chk("err_check", 32'(err), 32'(m_err));
    chk("errcnt_check", 32'(errcnt), 32'(m_cnt));
    chk("rd_off_check", 32'(rd), 32'd0);
    chk("busy_check", 32'(busy), 32'd1);
    step();
    xfer = xfer + rd_wait + 1 + 1;
`else
    rd_xor = rd_xor ^ 32'(rd_wait);
`endif
    chk("busy_rot", 32'(busy), 32'd1);
    chk("wr_off_rot", 32'(wr), 32'd0);
    chk("rd_off_rot", 32'(rd), 32'd0);
    step();
    m_pat = (m_pat << 1) | (m_pat >> 31);
    chk("wdata_rot", wdata, m_pat);
    chk("busy_after", 32'(busy), 32'd0);
    chk("err_after", 32'(err), 32'(m_err));
    chk("errcnt_after", 32'(errcnt), 32'(m_cnt));
    exp_gap = int'(Period) + 1 + xfer;
  endtask

  task automatic reset_mid_xfer();
    bit ok;
    expect_write_start(ok);
    if (ok) begin
      waitreq = 1'b1;
      step();
`ifdef QSYS_LED_MASTER_READBACK_EN
      waitreq = 1'b0;
      step();
      waitreq = 1'b1;
      step();
      chk("rd_before_rst", 32'(rd), 32'd1);
`else
      chk("wr_before_rst", 32'(wr), 32'd1);
`endif
    end
    #1 rst_n = 1'b0;
    #1;
    m_pat = InitPat;
    m_err = 1'b0;
    m_cnt = 16'd0;
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_wdata", wdata, m_pat);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errcnt", 32'(errcnt), 32'(m_cnt));
    waitreq = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    last_wr = cyc;
    exp_gap = int'(Period) + 2;
  endtask

  initial begin
    int ww;
    int rw;
    logic [31:0] xr;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    last_wr  = 0;
    exp_gap  = -1;
    m_pat    = InitPat;
    m_err    = 1'b0;
    m_cnt    = 16'd0;
    rst_n    = 1'b0;
    en       = 1'b1;
    waitreq  = 1'b0;
    rdata    = 32'd0;
    repeat (3) step();

    chk("reset_rd", 32'(rd), 32'd0);
    chk("reset_wr", 32'(wr), 32'd0);
    chk("reset_wdata", wdata, InitPat);
    chk("reset_addr", 32'(addr), 32'(Target));
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_errcnt", 32'(errcnt), 32'd0);

    rst_n   = 1'b1;
    last_wr = cyc;
    exp_gap = int'(Period) + 2;

    // Enable dropped as the first write appears: sequence completes, then idle.
    run_xfer(0, 0, 32'd0, 1'b1);
    idle_hold(2 * int'(Period));
    en      = 1'b1;
    last_wr = cyc;
    exp_gap = int'(Period) + 2;
    run_xfer(0, 0, 32'd0, 1'b0);
    run_xfer(3, 0, 32'd0, 1'b0);
    run_xfer(0, 2, 32'd0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      ww = int'($urandom_range(0, 3));
      rw = int'($urandom_range(0, 3));
      xr = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom);
      run_xfer(ww, rw, xr, 1'b0);
    end

    reset_mid_xfer();
    run_xfer(0, 0, 32'h00000A5A, 1'b0);
    run_xfer(1, 1, 32'hFFFF0000, 1'b0);
    run_xfer(0, 0, 32'd0, 1'b0);

    // Drop enable while waiting for the tick.
    en = 1'b0;
    step();
    idle_hold(int'(Period) + 6);
    en      = 1'b1;
    last_wr = cyc;
    exp_gap = int'(Period) + 2;
    run_xfer(2, 0, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
